mem_arbiter: RTL
================

Name: mem_arbiter

Overview:
- Round-robin arbiter between NCORES core load/store ports and the shared single-port data memory.
- Sits directly upstream of the data memory.
- Each core holds a request until it is acknowledged. One memory command is issued per cycle, and the load data is routed back to the requesting core.
- Data memory contract: it samples addr, din, write and load on the rising clk edge, and its read data is valid in the following cycle.

Parameters:
- NCORES, 2, number of requesting cores (2..8).
- TAM, 16, data and address word width.
- LMEM, 8, log2 of the memory depth (2^LMEM words).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous reset, active-low.
- core_req  in  NCORES  per-core request valid; held high until that core's ack.
- core_we  in  NCORES  per-core request type: 1 = store, 0 = load.
- core_addr  in  NCORES*TAM  per-core address; core i occupies bits [i*TAM +: TAM].
- core_wdata  in  NCORES*TAM  per-core store data, same packing as core_addr.
- core_ack  out  NCORES  one-cycle completion pulse per core.
- core_rdata  out  NCORES*TAM  load data; valid only while the matching core_ack bit is high.
- mem_addr  out  TAM  registered address to memory.
- mem_din  out  TAM  registered store data.
- mem_write  out  1  registered store strobe.
- mem_load  out  1  registered load strobe.
- mem_dout  in  TAM  memory read data, valid one cycle after mem_load.

Behaviour:
- Reset (rst=0, asynchronous):
  - core_ack, mem_write, mem_load, mem_addr and mem_din are 0.
  - The busy[] flags, the response pipeline and the rr pointer are cleared (rr=0).
  - Any in-flight access is dropped and no ack is produced for it.
- Eligibility:
  - Core i is eligible when core_req[i]=1 and busy[i]=0.
- Arbitration (cycle T):
  - The winner is the first eligible core scanning i = rr, rr+1, ... modulo NCORES.
- Issue (edge ending cycle T):
  - mem_addr and mem_din take the winner's fields; mem_write = we and mem_load = !we.
  - busy[winner] is set to 1.
  - rr becomes winner+1, modulo NCORES.
  - The stage-1 register takes {valid=1, id=winner, we}.
  - With no eligible core, mem_write=0 and mem_load=0, and mem_addr/mem_din hold their previous values.
- Pipeline:
  - Cycle T+1: the command is at memory. At the edge ending T+1, stage 1 moves to stage 2.
  - Cycle T+2: stage-2 valid drives core_ack[id]=1. For a load, core_rdata[id] = mem_dout; otherwise core_rdata is 0.
  - At the edge ending T+2, busy[id] is cleared. The core updates or drops its req at that edge.
  - Latency from req-high to ack is 2 cycles when the core wins immediately.
  - The same core's next request is eligible from T+3.
- Throughput:
  - One command per cycle across cores; back-to-back issue to different cores is allowed.
  - A single core is limited to one access per 3 cycles.
- Other rules:
  - At most one core_ack bit is high in any cycle.
  - core_req dropped before grant: the request is withdrawn with no side effect.
  - core_req changes while busy are ignored.
  - Address handling without the optional feature: only the low LMEM bits are meaningful; the upper bits of mem_addr are passed through unchanged.

Optional Feature:
- Macro MEM_ARB_ADDR_CHECK_EN.
- Defined:
  - Adds port core_err, out, NCORES.
  - A winner with core_addr >= 2^LMEM is still granted and still sets busy, but mem_write and mem_load stay 0.
  - Two cycles later it gets core_ack=1, core_err=1 and core_rdata=0.
  - core_err is 0 otherwise and is 0 on reset.
- Undefined:
  - No core_err port; addresses are passed through unchecked.

Test Plan:
- Reset: hold rst=0 with random core inputs -> all outputs 0. After release with no requests -> mem_write=mem_load=0 indefinitely.
- Single load: core0 load addr 0x0010 (memory holds 0xBEEF) -> mem_load=1 in cycle 1; core_ack[0]=1 with core_rdata0=0xBEEF in cycle 2.
- Store then load: core1 stores 0x1234 to 0x0005 and, after its ack, loads 0x0005 -> mem_write with mem_din=0x1234 observed; the later ack returns 0x1234.
- Contention: both cores request every cycle, core0 addr 0x0001, core1 addr 0x0002 -> grants alternate 0,1,0,1 from rr=0; acks never overlap.
- Reset mid-op: assert rst during cycle T+1 of a core0 load -> no core_ack follows; after release a new core1 request is granted first (rr=0, core0 idle).
- With MEM_ARB_ADDR_CHECK_EN, LMEM=8: core0 load addr 0x0100 -> no mem_load; core_ack[0]=1, core_err[0]=1, core_rdata0=0 in cycle 2.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter between NCORES core load/store ports and
// one shared single-port data memory.
//
// Handshake: a core raises core_req[i] with core_we/core_addr/core_wdata and
// holds all of them until core_ack[i] pulses for one cycle. A granted command
// appears on the registered mem_* outputs the cycle after the grant. The ack
// (with load data taken straight from mem_dout) follows one cycle later, so a
// core that wins at once sees its ack two cycles after raising core_req. While
// a core is busy, its request lines are not looked at. A core may issue again
// in the cycle right after its ack.
//
// Optional feature macro: MEM_ARB_ADDR_CHECK_EN adds core_err and suppresses
// the memory strobe for addresses at or above 2^LMEM.
module mem_arbiter #(
  parameter int NCORES = 2,
  parameter int TAM    = 16,
  parameter int LMEM   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NCORES-1:0]     core_req,
  input  logic [NCORES-1:0]     core_we,
  input  logic [NCORES*TAM-1:0] core_addr,
  input  logic [NCORES*TAM-1:0] core_wdata,
  output logic [NCORES-1:0]     core_ack,
  output logic [NCORES*TAM-1:0] core_rdata,
`ifdef MEM_ARB_ADDR_CHECK_EN
  output logic [NCORES-1:0]     core_err,
`endif
  output logic [TAM-1:0]        mem_addr,
  output logic [TAM-1:0]        mem_din,
  output logic                  mem_write,
  output logic                  mem_load,
  input  logic [TAM-1:0]        mem_dout
);

  localparam int IDW = (NCORES > 1) ? $clog2(NCORES) : 1;

`ifdef MEM_ARB_ADDR_CHECK_EN
  localparam bit ADDR_CHECK = 1'b1;
`else
  localparam bit ADDR_CHECK = 1'b0;
`endif

  logic [NCORES-1:0] busy;
  logic [NCORES-1:0] elig;
  logic [NCORES-1:0] set_mask;
  logic [NCORES-1:0] clr_mask;
  logic [IDW-1:0]    rr;
  logic [IDW-1:0]    rr_next;
  logic [IDW-1:0]    cand;
  logic [IDW-1:0]    win_id;
  logic              win_found;
  logic              win_we;
  logic              win_err;
  logic [TAM-1:0]    win_addr;
  logic [TAM-1:0]    win_wdata;

  // Stage 1 tracks the command sitting at the memory, stage 2 the one whose
  // read data is on mem_dout this cycle.
  logic              s1_valid;
  logic [IDW-1:0]    s1_id;
  logic              s1_we;
  logic              s1_err;
  logic              s2_valid;
  logic [IDW-1:0]    s2_id;
  logic              s2_we;
  logic              s2_err;

  // Round-robin scan for the first eligible core starting at rr.
  always_comb begin
    elig      = core_req & ~busy;
    win_found = 1'b0;
    win_id    = '0;
    cand      = '0;
    for (int k = 0; k < NCORES; k++) begin
      cand = IDW'((int'(rr) + k) % NCORES);
      if (!win_found && elig[cand]) begin
        win_found = 1'b1;
        win_id    = cand;
      end
    end
    win_addr  = core_addr[win_id*TAM +: TAM];
    win_wdata = core_wdata[win_id*TAM +: TAM];
    win_we    = core_we[win_id];
    win_err   = ADDR_CHECK && ((win_addr >> LMEM) != '0);
    rr_next   = IDW'((int'(win_id) + 1) % NCORES);
    set_mask  = win_found ? (NCORES'(1) << win_id) : '0;
    clr_mask  = s2_valid ? (NCORES'(1) << s2_id) : '0;
  end

  // Issue the winner to memory, advance the pointer and the response pipeline.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy      <= '0;
      rr        <= '0;
      mem_addr  <= '0;
      mem_din   <= '0;
      mem_write <= 1'b0;
      mem_load  <= 1'b0;
      s1_valid  <= 1'b0;
      s1_id     <= '0;
      s1_we     <= 1'b0;
      s1_err    <= 1'b0;
      s2_valid  <= 1'b0;
      s2_id     <= '0;
      s2_we     <= 1'b0;
      s2_err    <= 1'b0;
    end else begin
      busy     <= (busy & ~clr_mask) | set_mask;
      s2_valid <= s1_valid;
      s2_id    <= s1_id;
      s2_we    <= s1_we;
      s2_err   <= s1_err;
      if (win_found) begin
        mem_addr  <= win_addr;
        mem_din   <= win_wdata;
        mem_write <= win_we & ~win_err;
        mem_load  <= ~win_we & ~win_err;
        rr        <= rr_next;
        s1_valid  <= 1'b1;
        s1_id     <= win_id;
        s1_we     <= win_we;
        s1_err    <= win_err;
      end else begin
        mem_write <= 1'b0;
        mem_load  <= 1'b0;
        s1_valid  <= 1'b0;
      end
    end
  end

  // Decode the stage-2 entry into the per-core ack and load data.
  always_comb begin
    core_ack   = '0;
    core_rdata = '0;
    if (s2_valid) core_ack[s2_id] = 1'b1;
    for (int i = 0; i < NCORES; i++) begin
      if (core_ack[i] && !s2_we && !s2_err) core_rdata[i*TAM +: TAM] = mem_dout;
    end
  end

`ifdef MEM_ARB_ADDR_CHECK_EN
  // Out-of-range access completes with an error flag instead of data.
  always_comb begin
    core_err = '0;
    if (s2_valid && s2_err) core_err[s2_id] = 1'b1;
  end
`endif

endmodule
